// File: rtl/uart_rx_apb_sequencer_if.sv
// APB master bus plus received-byte valid/ready stream of uart_rx_apb_sequencer.
interface uart_rx_apb_sequencer_if;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [2:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pslverr;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pslverr,
        output rx_byte, rx_valid,
        input  rx_ready
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pslverr,
        input  rx_byte, rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_apb_sequencer.sv
// Configures and polls a UART RX APB slave, draining bytes into a byte FIFO.
// Optional `RX_TIMEOUT_EN builds an idle-poll timeout pulse on rx_timeout.
module uart_rx_apb_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int POLL_GAP   = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           cfg_start,
    input  logic                           run,
    input  logic [13:0]                    cfg_bit_period,
    input  logic [3:0]                     cfg_data_size,
    uart_rx_apb_sequencer_if.master        bus,
    output logic [2:0]                     err_flags,
    output logic [7:0]                     err_count,
    output logic                           busy,
    output logic                           rx_timeout
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(POLL_GAP + 1);

    typedef enum logic [3:0] {
        IDLE, CFG_LO, CFG_HI, CFG_DS, GAP,
        POLL_STAT, WAIT_SPACE, RD_ERR, RD_DATA
    } state_t;

    typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_t;

    state_t        state, state_n;
    phase_t        ph, ph_n;
    logic [GW-1:0] gap_cnt, gap_n;

    logic [13:0]   bp_q;
    logic [3:0]    ds_q;
    logic          discard;

    logic          latch_cfg, set_cfg_err, set_ovr, set_frm;
    logic          push, data_done, xfer, acc;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, do_push;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign pop     = bus.rx_valid & bus.rx_ready;
    assign do_push = push & (~full | pop);

    assign xfer = (state == CFG_LO) || (state == CFG_HI) ||
                  (state == CFG_DS) || (state == POLL_STAT) ||
                  (state == RD_ERR) || (state == RD_DATA);
    assign acc  = xfer && (ph == PH_ACCESS);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            ph      <= PH_IDLE;
            gap_cnt <= '0;
        end else begin
            state   <= state_n;
            ph      <= ph_n;
            gap_cnt <= gap_n;
        end
    end

    // Transfer states walk PH_IDLE -> PH_SETUP -> PH_ACCESS; entering at
    // PH_IDLE inserts the mandatory psel=0 cycle between back-to-back reads.
    always_comb begin
        state_n     = state;
        ph_n        = ph;
        gap_n       = gap_cnt;
        latch_cfg   = 1'b0;
        set_cfg_err = 1'b0;
        set_ovr     = 1'b0;
        set_frm     = 1'b0;
        push        = 1'b0;
        data_done   = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    latch_cfg = 1'b1;
                    state_n   = CFG_LO;
                    ph_n      = PH_SETUP;
                end
            end
            CFG_LO, CFG_HI, CFG_DS: begin
                if (acc) begin
                    ph_n = PH_IDLE;
                    if (bus.pslverr) begin
                        set_cfg_err = 1'b1;
                        state_n     = IDLE;
                    end else if (state == CFG_DS) begin
                        state_n = GAP;
                        gap_n   = '0;
                    end else begin
                        state_n = (state == CFG_LO) ? CFG_HI : CFG_DS;
                    end
                end else begin
                    ph_n = phase_t'(ph + 2'd1);
                end
            end
            GAP: begin
                if (gap_cnt == GW'(POLL_GAP - 1)) begin
                    state_n = run ? POLL_STAT : IDLE;
                    ph_n    = run ? PH_SETUP : PH_IDLE;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            POLL_STAT: begin
                if (acc) begin
                    ph_n  = PH_IDLE;
                    gap_n = '0;
                    if (!run)
                        state_n = IDLE;
                    else if (!bus.prdata[0])
                        state_n = GAP;
                    else if (full)
                        state_n = WAIT_SPACE;
                    else
                        state_n = RD_ERR;
                end else begin
                    ph_n = phase_t'(ph + 2'd1);
                end
            end
            WAIT_SPACE: begin
                if (!run) begin
                    state_n = IDLE;
                end else if (!full) begin
                    state_n = RD_ERR;
                    ph_n    = PH_SETUP;
                end
            end
            RD_ERR, RD_DATA: begin
                if (ph == PH_IDLE && !run) begin
                    state_n = IDLE;
                end else if (acc) begin
                    ph_n  = PH_IDLE;
                    gap_n = '0;
                    if (state == RD_ERR) begin
                        set_ovr = bus.prdata[1];
                        set_frm = bus.prdata[0];
                        state_n = run ? RD_DATA : IDLE;
                    end else begin
                        push      = ~discard;
                        data_done = 1'b1;
                        state_n   = run ? GAP : IDLE;
                    end
                end else begin
                    ph_n = phase_t'(ph + 2'd1);
                end
            end
            default: begin
                state_n = IDLE;
                ph_n    = PH_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.psel    = xfer && (ph != PH_IDLE);
        bus.penable = acc;
        bus.pwrite  = 1'b0;
        bus.paddr   = 3'd0;
        bus.pwdata  = 8'd0;
        if (bus.psel) begin
            case (state)
                CFG_LO: begin
                    bus.pwrite = 1'b1;
                    bus.paddr  = 3'd2;
                    bus.pwdata = bp_q[7:0];
                end
                CFG_HI: begin
                    bus.pwrite = 1'b1;
                    bus.paddr  = 3'd3;
                    bus.pwdata = {2'b00, bp_q[13:8]};
                end
                CFG_DS: begin
                    bus.pwrite = 1'b1;
                    bus.paddr  = 3'd4;
                    bus.pwdata = {4'b0000, ds_q};
                end
                RD_ERR:  bus.paddr = 3'd1;
                RD_DATA: bus.paddr = 3'd6;
                default: bus.paddr = 3'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bp_q      <= '0;
            ds_q      <= '0;
            discard   <= 1'b0;
            err_flags <= '0;
            err_count <= '0;
        end else begin
            if (latch_cfg) begin
                bp_q      <= cfg_bit_period;
                ds_q      <= cfg_data_size;
                err_flags <= '0;
            end else begin
                err_flags <= err_flags | {set_cfg_err, set_ovr, set_frm};
            end
            if (set_frm && err_count != 8'hFF)
                err_count <= err_count + 1'b1;
            if (state == IDLE || data_done)
                discard <= 1'b0;
            else if (set_frm)
                discard <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= bus.prdata;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.rx_valid = (count != '0);
    assign bus.rx_byte  = bus.rx_valid ? mem[rd_ptr] : 8'd0;
    assign busy         = (state != IDLE);

`ifdef RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);

    logic [TW-1:0] to_cnt;
    logic          to_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            to_cnt <= '0;
            to_q   <= 1'b0;
        end else begin
            to_q <= 1'b0;
            if (state == IDLE || do_push) begin
                to_cnt <= '0;
            end else if (state == GAP || state == POLL_STAT) begin
                if (to_cnt == TW'(TIMEOUT - 1)) begin
                    to_cnt <= '0;
                    to_q   <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

    assign rx_timeout = to_q;
`else
    assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_apb_sequencer.sv
// Directed bench: scripted APB slave, transfer log and byte scoreboard.
module tb_uart_rx_apb_sequencer;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        cfg_start = 1'b0;
    logic        run = 1'b0;
    logic [13:0] cfg_bit_period = '0;
    logic [3:0]  cfg_data_size = '0;
    logic [2:0]  err_flags;
    logic [7:0]  err_count;
    logic        busy;
    logic        rx_timeout;

    uart_rx_apb_sequencer_if bus();

    uart_rx_apb_sequencer dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .cfg_start      (cfg_start),
        .run            (run),
        .cfg_bit_period (cfg_bit_period),
        .cfg_data_size  (cfg_data_size),
        .bus            (bus),
        .err_flags      (err_flags),
        .err_count      (err_count),
        .busy           (busy),
        .rx_timeout     (rx_timeout)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] pend_dat [64];
    logic [7:0] pend_err [64];
    int hd = 0;
    int tl = 0;
    int err_addr = -1;
    logic [7:0] exp_q [$];

    assign bus.prdata = (bus.paddr == 3'd0) ? {7'd0, (tl != hd)} :
                        (bus.paddr == 3'd1) ? pend_err[hd] :
                        (bus.paddr == 3'd6) ? pend_dat[hd] : 8'd0;
    assign bus.pslverr = bus.psel && bus.penable && bus.pwrite &&
                         (int'(bus.paddr) == err_addr);

    typedef struct {
        logic       w;
        logic [2:0] a;
        logic [7:0] d;
        int         cyc;
    } xfer_t;

    xfer_t xlog [$];
    int cyc = 0;
    int proto_err = 0;
    logic pv_sel = 1'b0;
    logic pv_en = 1'b0;
    logic [2:0] pv_addr = '0;
    logic [7:0] pv_wd = '0;

    always @(posedge clk) begin
        cyc++;
        if (!n_rst) begin
            pv_sel = 1'b0;
            pv_en  = 1'b0;
        end else begin
            if (bus.psel && bus.penable) begin
                if (!(pv_sel && !pv_en) || bus.paddr != pv_addr)
                    proto_err++;
                if (bus.pwrite && bus.pwdata != pv_wd)
                    proto_err++;
                xlog.push_back('{bus.pwrite, bus.paddr,
                                 bus.pwrite ? bus.pwdata : bus.prdata, cyc});
                if (!bus.pwrite && bus.paddr == 3'd6)
                    hd <= hd + 1;
            end
            if (bus.psel && !bus.penable && pv_sel)
                proto_err++;
            pv_sel  = bus.psel;
            pv_en   = bus.penable;
            pv_addr = bus.paddr;
            pv_wd   = bus.pwdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic add_rx(input logic [7:0] e, input logic [7:0] d,
                          input bit deliver);
        pend_err[tl] = e;
        pend_dat[tl] = d;
        tl++;
        if (deliver)
            exp_q.push_back(d);
    endtask

    task automatic wait_hd(input int target, input string tag);
        int n = 0;
        while (hd != target && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, hd, target);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.rx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, bus.rx_valid, 1);
    endtask

    task automatic wait_busy(input logic v, input string tag);
        int n = 0;
        while (busy !== v && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy, v);
    endtask

    task automatic wait_log(input int sz, input string tag);
        int n = 0;
        while (xlog.size() < sz && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, xlog.size() >= sz, 1);
    endtask

    task automatic pop_chk(input string tag);
        logic [7:0] e;
        e = exp_q.pop_front();
        chk({tag, "_valid"}, bus.rx_valid, 1);
        chk({tag, "_byte"}, bus.rx_byte, e);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
    endtask

    task automatic start_pulse();
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        int n;
        int cnt;
        bus.rx_ready = 1'b0;
        @(negedge clk);
        chk("rst_psel", bus.psel, 0);
        chk("rst_penable", bus.penable, 0);
        chk("rst_paddr", bus.paddr, 0);
        chk("rst_valid", bus.rx_valid, 0);
        chk("rst_byte", bus.rx_byte, 0);
        chk("rst_flags", err_flags, 0);
        chk("rst_count", err_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", rx_timeout, 0);

        n_rst = 1'b1;
        run = 1'b1;
        cfg_bit_period = 14'h1A5;
        cfg_data_size = 4'd7;
        tick(1);
        start_pulse();
        wait_log(4, "cfg_wait");
        chk("cfg_lo", {xlog[0].w, xlog[0].a, xlog[0].d}, {1'b1, 3'd2, 8'hA5});
        chk("cfg_hi", {xlog[1].w, xlog[1].a, xlog[1].d}, {1'b1, 3'd3, 8'h01});
        chk("cfg_ds", {xlog[2].w, xlog[2].a, xlog[2].d}, {1'b1, 3'd4, 8'h07});
        chk("cfg_spacing", xlog[1].cyc - xlog[0].cyc, 3);
        chk("poll_first", {xlog[3].w, xlog[3].a, xlog[3].d}, {1'b0, 3'd0, 8'h00});
        chk("poll_gap", xlog[3].cyc - xlog[2].cyc, 10);

        add_rx(8'h00, 8'h5C, 1'b1);
        wait_valid("rx_wait");
        n = xlog.size();
        chk("rx_seq", {xlog[n-3].a, xlog[n-2].a, xlog[n-1].a},
            {3'd0, 3'd1, 3'd6});
        pop_chk("rx");
        chk("rx_drained", bus.rx_valid, 0);

        add_rx(8'h01, 8'hEE, 1'b0);
        wait_hd(tl, "frm_wait");
        tick(1);
        chk("frm_flags", err_flags, 3'b001);
        chk("frm_count", err_count, 1);
        chk("frm_nopush", bus.rx_valid, 0);

        add_rx(8'h02, 8'h33, 1'b1);
        wait_valid("ovr_wait");
        chk("ovr_flags", err_flags, 3'b011);
        pop_chk("ovr");

        h0 = hd;
        for (int i = 0; i < 5; i++)
            add_rx(8'h00, 8'h10 + 8'(i), 1'b1);
        wait_hd(h0 + 4, "bp_fill");
        tick(14);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.psel) cnt++;
            @(negedge clk);
        end
        chk("bp_nopsel", cnt, 0);
        chk("bp_hold", hd, h0 + 4);
        chk("bp_busy", busy, 1);
        n = xlog.size();
        pop_chk("bp0");
        wait_hd(h0 + 5, "bp_refill");
        chk("bp_seq", {xlog[n].w, xlog[n].a, xlog[n+1].w, xlog[n+1].a},
            {1'b0, 3'd1, 1'b0, 3'd6});
        tick(20);
        for (int i = 0; i < 4; i++)
            pop_chk("bp_drain");
        chk("bp_empty", bus.rx_valid, 0);

        add_rx(8'h00, 8'h77, 1'b1);
        add_rx(8'h00, 8'h78, 1'b1);
        wait_hd(tl, "ret_wait");
        tick(1);
        run = 1'b0;
        wait_busy(1'b0, "run_idle");
        pop_chk("ret0");
        chk("ret1_valid", bus.rx_valid, 1);

        err_addr = 3;
        run = 1'b1;
        cfg_bit_period = 14'h2B3F;
        cfg_data_size = 4'd8;
        n = xlog.size();
        start_pulse();
        chk("cerr_busy", busy, 1);
        wait_busy(1'b0, "cerr_idle");
        tick(5);
        chk("cerr_flags", err_flags, 3'b100);
        chk("cerr_count", err_count, 1);
        chk("cerr_nxfer", xlog.size() - n, 2);
        chk("cerr_lo", {xlog[n].w, xlog[n].a, xlog[n].d}, {1'b1, 3'd2, 8'h3F});
        chk("cerr_hi", {xlog[n+1].w, xlog[n+1].a, xlog[n+1].d},
            {1'b1, 3'd3, 8'h2B});
        chk("cerr_still_idle", busy, 0);
        chk("cerr_fifo_kept", bus.rx_byte, 8'h78);

        err_addr = -1;
        start_pulse();
        cnt = 0;
        while (!bus.penable && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        chk("ar_in_access", bus.penable, 1);
        #2;
        n_rst = 1'b0;
        #1;
        chk("ar_psel", bus.psel, 0);
        chk("ar_penable", bus.penable, 0);
        chk("ar_busy", busy, 0);
        chk("ar_valid", bus.rx_valid, 0);
        chk("ar_byte", bus.rx_byte, 0);
        chk("ar_flags", err_flags, 0);
        chk("ar_count", err_count, 0);
        exp_q.delete();
        @(negedge clk);
        n_rst = 1'b1;
        tick(3);
        chk("ar_stays_idle", busy, 0);
        chk("protocol", proto_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_apb_sequencer.md
Name: uart_rx_apb_sequencer

Overview:
APB master that configures and services the UART receiver's APB register block without software involvement. On a start pulse it writes bit period and data size, then continuously polls status, checks errors and drains received bytes into an internal FIFO. The FIFO is exposed as a valid/ready byte stream. It sits between the UART RX APB slave and downstream byte consumers, such as a packet parser.

Parameters:
FIFO_DEPTH, 4, output byte FIFO entries (power of 2, >=2)
POLL_GAP, 8, idle cycles between consecutive status polls (>=1)
TIMEOUT, 1024, idle-poll cycles before timeout pulse (only with RX_TIMEOUT_EN)

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous, active-low reset
cfg_start  in  1  pulse: latch cfg values, run configuration, enter polling
run  in  1  level: polling enabled; deassert -> finish current transfer, go IDLE
cfg_bit_period  in  14  bit period to program
cfg_data_size  in  4  data size to program
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB write
paddr  out  3  APB address
pwdata  out  8  APB write data
prdata  in  8  APB read data
pslverr  in  1  APB slave error
rx_byte  out  8  FIFO head byte
rx_valid  out  1  FIFO non-empty
rx_ready  in  1  consumer accepts head when rx_valid&rx_ready
err_flags  out  3  sticky {cfg_err, overrun, framing}
err_count  out  8  framing errors seen, saturates at 255
busy  out  1  not in IDLE
rx_timeout  out  1  one-cycle pulse (RX_TIMEOUT_EN only)

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE; err_flags/err_count cleared; latched cfg cleared.
- Register map used: 0 status (prdata[0]=data_ready), 1 errors (bit0 framing, bit1 overrun), 2 bit_period[7:0], 3 bit_period[13:8] (pwdata[7:6]=0), 4 data_size (pwdata[7:4]=0), 6 rx data.
- APB transfer format: setup cycle (psel=1, penable=0), then access cycle (psel=1, penable=1); slave is zero-wait.
- prdata and pslverr are sampled on the clock edge that ends the access cycle.
- At least one psel=0 cycle follows every transfer.
- paddr, pwrite and pwdata are held stable across setup and access.
- States: IDLE, CFG_LO, CFG_HI, CFG_DS, GAP, POLL_STAT, WAIT_SPACE, RD_ERR, RD_DATA.
- IDLE: cfg_start=1 -> latch cfg, go CFG_LO. cfg_start is ignored outside IDLE.
- CFG_LO/CFG_HI/CFG_DS: writes to addr 2, 3, 4 in that order, then GAP.
- pslverr on any config write -> set err_flags[2], go IDLE immediately.
- GAP: count POLL_GAP idle cycles, then POLL_STAT. If run=0 at GAP exit -> IDLE.
- POLL_STAT: read addr 0.
  - prdata[0]=0 -> GAP.
  - prdata[0]=1 and FIFO full -> WAIT_SPACE.
  - prdata[0]=1 and FIFO not full -> RD_ERR.
- WAIT_SPACE: no bus activity; leave for RD_ERR the cycle after FIFO is not full.
- RD_ERR: read addr 1.
  - bit1=1 -> set err_flags[1].
  - bit0=1 -> set err_flags[0], err_count+1 (saturating), mark byte discard.
  - Then RD_DATA.
- RD_DATA: read addr 6. Push prdata unless marked discard; clear discard flag; go GAP.
- FIFO:
  - Push and pop in the same cycle is allowed; when full, that pair is legal and the count is unchanged.
  - Push when full cannot occur, because WAIT_SPACE guarantees space.
  - Pop when empty has no effect.
  - rx_byte is valid whenever rx_valid=1.
  - Pointers wrap modulo FIFO_DEPTH.
- run=0 mid-transfer: complete the access cycle, then IDLE. FIFO contents are retained and drainable in IDLE.
- err_flags are cleared only by reset or by cfg_start.
- Asynchronous reset mid-transfer: psel/penable drop immediately and FIFO empties.

Optional Feature:
RX_TIMEOUT_EN:
- Defined: a counter increments each cycle while state is GAP or POLL_STAT and no byte has been pushed. It clears on a push or in IDLE.
- On reaching TIMEOUT-1, rx_timeout pulses for one cycle and the counter clears.
- Undefined: rx_timeout is tied 0 and no counter is built.

Test Plan:
- Config: reset; cfg_bit_period=0x1A5, cfg_data_size=7, cfg_start -> writes (2,0xA5), (3,0x01), (4,0x07) in order, each setup+access with psel=0 between; then first status read after 8 idle cycles.
- Receive: status returns 0x01, errors 0x00, data 0x5C -> rx_valid=1, rx_byte=0x5C; rx_ready=1 -> rx_valid=0 next cycle.
- Framing: errors reg returns 0x01 -> addr 6 still read, no push, err_flags=3'b001, err_count=1.
- Overrun: errors reg returns 0x02 -> byte pushed, err_flags[1]=1.
- Backpressure: rx_ready=0 and 4 bytes received -> next data_ready=1 leads to WAIT_SPACE with no psel. One pop -> RD_ERR then RD_DATA, and FIFO is full again.
- Config error: pslverr=1 on addr 3 write -> err_flags[2]=1, busy=0, no addr 4 write. Also: reset asserted mid-access -> all outputs 0 asynchronously.
